// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter over 32 level-sensitive requesters with registered one-hot grant.
// Optional hold-time limit enabled by defining ARB_TIMEOUT_EN (limit set by HOLD_MAX).
module rr_decoder_arbiter #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iEna,
    input  logic [31:0] iReq,
    output logic [31:0] oGnt,
    output logic [4:0]  oGntIdx,
    output logic        oValid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state, state_n;
    logic [4:0]  ptr, ptr_n;
    logic [4:0]  idx, idx_n;
    logic [31:0] gnt, gnt_n;
    logic [31:0] others;
    logic [5:0]  pick_first, pick_next;
    logic        release_grant;
    logic        timeout_hit;
    logic        load_grant;

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_range
        $error("HOLD_MAX must be within 1..255");
    end

    // Returns {found, index} of the first set bit walking upward from start with wrap.
    function automatic logic [5:0] pick(input logic [31:0] req, input logic [4:0] start);
        logic [5:0] res;
        logic [4:0] k;
        res = '0;
        for (int i = 31; i >= 0; i--) begin
            k = start + 5'(i);
            if (req[k]) res = {1'b1, k};
        end
        return res;
    endfunction

    assign others     = iReq & ~(32'd1 << idx);
    assign pick_first = pick(iReq, ptr);
    assign pick_next  = pick(others, idx + 5'd1);

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;

    // hold_cnt lags the number of granted cycles by one, hence the HOLD_MAX-1 compare.
    assign timeout_hit = (hold_cnt >= 8'(HOLD_MAX - 1)) && (others != '0);

    always_ff @(posedge iClk) begin
        if (iRst || load_grant) begin
            hold_cnt <= '0;
        end else if (state == GRANT && hold_cnt < 8'(HOLD_MAX)) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign release_grant = !iReq[idx] || timeout_hit;

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        idx_n      = idx;
        load_grant = 1'b0;
        case (state)
            IDLE: begin
                if (iEna && iReq != '0) begin
                    state_n    = GRANT;
                    idx_n      = pick_first[4:0];
                    load_grant = 1'b1;
                end
            end
            GRANT: begin
                if (!iEna) begin
                    state_n = IDLE;
                    idx_n   = '0;
                end else if (release_grant) begin
                    // Released requester is masked out so it cannot win its own handover.
                    ptr_n = idx + 5'd1;
                    if (pick_next[5]) begin
                        idx_n      = pick_next[4:0];
                        load_grant = 1'b1;
                    end else begin
                        state_n = IDLE;
                        idx_n   = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
        gnt_n = (state_n == GRANT) ? (32'd1 << idx_n) : '0;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
            ptr   <= '0;
            idx   <= '0;
            gnt   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            idx   <= idx_n;
            gnt   <= gnt_n;
        end
    end

    assign oValid  = (state == GRANT);
    assign oGntIdx = idx;
    assign oGnt    = gnt;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Scoreboard bench for rr_decoder_arbiter: a reference model predicts each cycle's outputs.
module tb_rr_decoder_arbiter;

    localparam int HOLD = 15;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iEna;
    logic [31:0] iReq;
    logic [31:0] oGnt;
    logic [4:0]  oGntIdx;
    logic        oValid;

    rr_decoder_arbiter #(.HOLD_MAX(HOLD)) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iEna    (iEna),
        .iReq    (iReq),
        .oGnt    (oGnt),
        .oGntIdx (oGntIdx),
        .oValid  (oValid)
    );

    always #5 iClk = ~iClk;

    typedef struct packed {
        logic        valid;
        logic [4:0]  idx;
        logic [31:0] gnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks   = 0;
    int   failures = 0;

    // Reference model: grant owner, round-robin start point, cycles granted so far.
    bit          m_valid = 1'b0;
    int          m_idx   = 0;
    int          m_ptr   = 0;
    int          m_hold  = 0;
    logic [31:0] req_cur;

    function automatic int first_set(input logic [31:0] req, input int start);
        for (int o = 0; o < 32; o++) begin
            int j;
            j = (start + o) % 32;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic [31:0] req);
        logic [31:0] oth;
        int          nxt;
        exp_t        x;
        if (r) begin
            m_valid = 1'b0; m_idx = 0; m_ptr = 0; m_hold = 0;
        end else if (!m_valid) begin
            if (e && req != 0) begin
                m_idx = first_set(req, m_ptr); m_valid = 1'b1; m_hold = 1;
            end
        end else if (!e) begin
            m_valid = 1'b0; m_idx = 0;
        end else begin
            oth = req & ~(32'd1 << m_idx);
            if (!req[m_idx] || (TMO && m_hold >= HOLD && oth != 0)) begin
                m_ptr = (m_idx + 1) % 32;
                nxt   = first_set(oth, m_ptr);
                if (nxt >= 0) begin
                    m_idx = nxt; m_hold = 1;
                end else begin
                    m_valid = 1'b0; m_idx = 0; m_hold = 0;
                end
            end else if (m_hold < 1000) begin
                m_hold++;
            end
        end
        x.valid = m_valid;
        x.idx   = 5'(m_idx);
        x.gnt   = m_valid ? (32'd1 << m_idx) : 32'd0;
        exp_q.push_back(x);
    endtask

    task automatic step(input logic r, input logic e, input logic [31:0] req);
        iRst = r; iEna = e; iReq = req;
        model_step(r, e, req);
        @(posedge iClk);
        #2;
    endtask

    always @(posedge iClk) begin
        #1;
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check("valid", {31'd0, oValid}, {31'd0, cur.valid});
            check("gnt_idx", {27'd0, oGntIdx}, {27'd0, cur.idx});
            check("gnt", oGnt, cur.gnt);
            check("gnt_onehot0", {31'd0, $onehot0(oGnt)}, 32'd1);
        end
    end

    initial begin
        iRst = 1'b1; iEna = 1'b0; iReq = '0;
        step(1, 0, 32'h0);
        step(1, 1, 32'hFFFF_FFFF);
        // single requester after reset
        step(0, 1, 32'h0000_0001);
        step(0, 1, 32'h0000_0001);
        // wrap-around 0 -> 31 -> 0
        step(1, 0, 32'h0);
        step(0, 1, 32'h8000_0001);
        step(0, 1, 32'h8000_0000);
        step(0, 1, 32'h0000_0001);
        step(0, 1, 32'h0000_0001);
        // back-to-back handover 4,5,6,7 then back to 4
        step(1, 0, 32'h0);
        step(0, 1, 32'h0000_00F0);
        step(0, 1, 32'h0000_00E0);
        step(0, 1, 32'h0000_00D0);
        step(0, 1, 32'h0000_00B0);
        step(0, 1, 32'h0000_0070);
        // released requester reasserting alone is not regranted at the release edge
        step(0, 1, 32'h0000_0000);
        step(1, 0, 32'h0);
        step(0, 1, 32'h0000_0008);
        step(0, 1, 32'h0000_0000);
        // enable drop mid-grant
        step(1, 0, 32'h0);
        step(0, 1, 32'h0000_0200);
        step(0, 0, 32'h0000_0200);
        step(0, 1, 32'h0000_0200);
        // reset mid-grant, arbitration restarts from pointer 0
        step(0, 1, 32'h0000_1000);
        step(0, 1, 32'h0000_0000);
        step(0, 1, 32'h0000_1000);
        step(1, 1, 32'h0010_1000);
        step(0, 1, 32'h0010_1000);
        // long hold with a competitor: timeout handover only when enabled
        step(1, 0, 32'h0);
        for (int i = 0; i < 20; i++) step(0, 1, 32'h0000_0006);
        step(1, 0, 32'h0);
        for (int i = 0; i < 20; i++) step(0, 1, 32'h0000_0002);
        // randomized traffic
        req_cur = '0;
        for (int i = 0; i < 800; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 3) req_cur = $urandom & $urandom & $urandom;
            else if (sel < 5 && m_valid) req_cur[m_idx] = 1'b0;
            else if (sel == 5) req_cur = req_cur | (32'd1 << $urandom_range(0, 31));
            step($urandom_range(0, 59) == 0, $urandom_range(0, 9) != 0, req_cur);
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge iClk);
        #3;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
